gradient_frame_ctrl: RTL and testbench

- Front-end sequencer for the gradient kernel pipeline.
- Accepts video on an AXI4-Stream slave and gates frames into the pixel datapath and M_AXIS output stage as `pixel/pixel_valid/start_of_frame`.
- Enforces frame geometry (tuser/tlast positions), runs single-shot or continuous capture, honours stop requests only at frame boundaries, and reports status/errors to control software.

---
 rtl/gradient_frame_ctrl_if.sv | 14 +
 rtl/gradient_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_gradient_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gradient_frame_ctrl_if.sv
// AXI4-Stream video beat bundle (tdata/tvalid/tuser/tlast/tready) feeding the gradient front end.
// The source side is the master; the frame controller is the slave.
interface gradient_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/gradient_frame_ctrl.sv
// Frame gate for the gradient kernel: checks tuser/tlast geometry, runs single-shot or
// continuous capture, and forwards accepted pixels one cycle later with status pulses.
module gradient_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10
) (
  input  logic                   i_clk,
  input  logic                   i_aresetn,
  input  logic                   i_start,
  input  logic                   i_continuous,
  input  logic                   i_stop,
  input  logic                   i_clear_err,
  gradient_frame_ctrl_if.slave   s_axis,
  output logic [DATA_WIDTH-1:0]  o_pixel,
  output logic                   o_pixel_valid,
  output logic                   o_start_of_frame,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_frame_abort,
  output logic [2:0]             o_err,
  output logic [15:0]            o_frame_count
);

  localparam logic [11:0] LAST_PIX  = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] LAST_LINE = 12'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, RESYNC} state_t;

  state_t      state, state_nxt;
  logic [11:0] pix_cnt, pix_nxt;
  logic [11:0] line_cnt, line_nxt;
  logic        stop_pending, stop_nxt;
  logic        fwd, sof, done, abort;
  logic [2:0]  err_set;
  logic        accept, last_pix;

  // Ready depends on state alone so the upstream source never sees a combinational loop.
  assign s_axis.tready = (state != IDLE);
  assign o_busy        = (state != IDLE);
  assign accept        = s_axis.tvalid & s_axis.tready;
  assign last_pix      = (pix_cnt == LAST_PIX);

  // NOTE: every signal is given a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    pix_nxt   = pix_cnt;
    line_nxt  = line_cnt;
    stop_nxt  = stop_pending;
    fwd       = 1'b0;
    sof       = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    err_set   = 3'b000;

    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = WAIT_SOF;
          stop_nxt  = 1'b0;
        end
      end

      WAIT_SOF, RESYNC: begin
        if (stop_pending || i_stop) begin
          state_nxt = IDLE;
        end else if (accept && s_axis.tuser) begin
          fwd      = 1'b1;
          sof      = 1'b1;
          pix_nxt  = 12'd1;
          line_nxt = 12'd0;
          if (s_axis.tlast && (IMG_WIDTH > 1)) begin
            err_set[0] = 1'b1;
            abort      = 1'b1;
            state_nxt  = RESYNC;
          end else begin
            state_nxt  = ACTIVE;
          end
        end
      end

      ACTIVE: begin
        stop_nxt = stop_pending | i_stop;
        if (accept) begin
          fwd = 1'b1;
          if (s_axis.tuser) begin
            // A premature sof restarts the frame on this very beat.
            err_set[2] = 1'b1;
            abort      = 1'b1;
            sof        = 1'b1;
            pix_nxt    = 12'd1;
            line_nxt   = 12'd0;
          end else if (s_axis.tlast && !last_pix) begin
            err_set[0] = 1'b1;
            abort      = 1'b1;
            state_nxt  = RESYNC;
          end else if (last_pix && !s_axis.tlast) begin
            err_set[1] = 1'b1;
            abort      = 1'b1;
            state_nxt  = RESYNC;
          end else if (last_pix && (line_cnt != LAST_LINE)) begin
            pix_nxt  = 12'd0;
            line_nxt = line_cnt + 12'd1;
          end else if (last_pix) begin
            done      = 1'b1;
            pix_nxt   = 12'd0;
            line_nxt  = 12'd0;
            state_nxt = (i_continuous && !stop_pending && !i_stop) ? WAIT_SOF : IDLE;
          end else begin
            pix_nxt = pix_cnt + 12'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state            <= IDLE;
      pix_cnt          <= '0;
      line_cnt         <= '0;
      stop_pending     <= 1'b0;
      o_pixel          <= '0;
      o_pixel_valid    <= 1'b0;
      o_start_of_frame <= 1'b0;
      o_frame_done     <= 1'b0;
      o_frame_abort    <= 1'b0;
      o_err            <= '0;
      o_frame_count    <= '0;
    end else begin
      state            <= state_nxt;
      pix_cnt          <= pix_nxt;
      line_cnt         <= line_nxt;
      stop_pending     <= stop_nxt;
      o_pixel_valid    <= fwd;
      o_start_of_frame <= sof;
      o_frame_done     <= done;
      o_frame_abort    <= abort;
      if (fwd) o_pixel <= s_axis.tdata;
      // Set wins over clear so a fresh error is never lost to a coincident clear.
      o_err            <= (o_err & ~{3{i_clear_err}}) | err_set;
      if (done) o_frame_count <= o_frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_gradient_frame_ctrl.sv
// Directed bench for gradient_frame_ctrl at 10x10: clean frames, geometry errors,
// stop handling and asynchronous reset, with hand-computed expectations.
module tb_gradient_frame_ctrl;

  logic        i_clk = 1'b0;
  logic        i_aresetn = 1'b0;
  logic        i_start = 1'b0, i_continuous = 1'b0, i_stop = 1'b0, i_clear_err = 1'b0;
  logic [7:0]  o_pixel;
  logic        o_pixel_valid, o_start_of_frame, o_busy, o_frame_done, o_frame_abort;
  logic [2:0]  o_err;
  logic [15:0] o_frame_count;

  gradient_frame_ctrl_if #(.DATA_WIDTH(8)) s_axis ();

  gradient_frame_ctrl #(.DATA_WIDTH(8), .IMG_WIDTH(10), .IMG_HEIGHT(10)) dut (
    .i_clk            (i_clk),
    .i_aresetn        (i_aresetn),
    .i_start          (i_start),
    .i_continuous     (i_continuous),
    .i_stop           (i_stop),
    .i_clear_err      (i_clear_err),
    .s_axis           (s_axis),
    .o_pixel          (o_pixel),
    .o_pixel_valid    (o_pixel_valid),
    .o_start_of_frame (o_start_of_frame),
    .o_busy           (o_busy),
    .o_frame_done     (o_frame_done),
    .o_frame_abort    (o_frame_abort),
    .o_err            (o_err),
    .o_frame_count    (o_frame_count)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Output monitor: cumulative event counts sampled on the falling edge.
  int n_pix = 0, n_sof = 0, n_done = 0, n_abort = 0, pix_sum = 0;
  int sof_idx = -1, done_idx = -1;
  logic done_vld = 1'b0;

  always @(negedge i_clk) begin
    if (o_pixel_valid) begin
      if (o_start_of_frame) begin
        n_sof++;
        sof_idx = n_pix;
      end
      n_pix++;
      pix_sum += int'(o_pixel);
    end
    if (o_frame_done) begin
      n_done++;
      done_idx = n_pix;
      done_vld = o_pixel_valid;
    end
    if (o_frame_abort) n_abort++;
  end

  int s_pix, s_sof, s_done, s_abort, s_sum;

  task automatic snap();
    s_pix = n_pix; s_sof = n_sof; s_done = n_done; s_abort = n_abort; s_sum = pix_sum;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the falling edge; one call presents one beat for one cycle.
  task automatic send(input logic [7:0] d, input logic u, input logic l);
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    s_axis.tuser  = u;
    s_axis.tlast  = l;
    @(negedge i_clk); #1;
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk); #1;
    end
  endtask

  // which: 0 start, 1 stop, 2 clear_err
  task automatic pulse(input int which);
    if (which == 0) i_start = 1'b1;
    if (which == 1) i_stop = 1'b1;
    if (which == 2) i_clear_err = 1'b1;
    @(negedge i_clk); #1;
    i_start = 1'b0; i_stop = 1'b0; i_clear_err = 1'b0;
  endtask

  task automatic do_reset();
    i_aresetn = 1'b0;
    @(negedge i_clk); #1;
    i_aresetn = 1'b1;
    @(negedge i_clk); #1;
  endtask

  // Clean 10x10 frame, data = beat index; optional one-cycle gaps and a stop on one beat.
  task automatic send_frame(input int gap_mod, input int stop_at);
    for (int i = 0; i < 100; i++) begin
      if (i == stop_at) i_stop = 1'b1;
      send(8'(i), (i == 0), (i % 10 == 9));
      i_stop = 1'b0;
      if (gap_mod > 0 && (i % gap_mod) == gap_mod - 1) idle(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tuser = 1'b0; s_axis.tlast = 1'b0;
    idle(3);
    check("rst_tready", 32'(s_axis.tready), 0);
    check("rst_busy",   32'(o_busy), 0);
    check("rst_valid",  32'(o_pixel_valid), 0);
    check("rst_err",    32'(o_err), 0);
    check("rst_count",  32'(o_frame_count), 0);
    i_aresetn = 1'b1;
    idle(2);

    // Single-shot clean frame
    i_continuous = 1'b0;
    pulse(0);
    check("ss_busy", 32'(o_busy), 1);
    snap();
    send_frame(0, -1);
    idle(2);
    check("ss_pixels",   32'(n_pix - s_pix), 100);
    check("ss_sofs",     32'(n_sof - s_sof), 1);
    check("ss_sof_idx",  32'(sof_idx), 32'(s_pix));
    check("ss_done",     32'(n_done - s_done), 1);
    check("ss_done_idx", 32'(done_idx), 32'(s_pix + 100));
    check("ss_done_vld", 32'(done_vld), 1);
    check("ss_sum",      32'(pix_sum - s_sum), 4950);
    check("ss_count",    32'(o_frame_count), 1);
    check("ss_busy_end", 32'(o_busy), 0);
    check("ss_tready",   32'(s_axis.tready), 0);
    check("ss_hold_pix", 32'(o_pixel), 99);

    // Continuous: garbage before sof, two frames with tvalid gaps
    do_reset();
    i_continuous = 1'b1;
    pulse(0);
    snap();
    repeat (3) send(8'hEE, 1'b0, 1'b0);
    send_frame(7, -1);
    send_frame(5, -1);
    idle(2);
    check("ct_pixels", 32'(n_pix - s_pix), 200);
    check("ct_sum",    32'(pix_sum - s_sum), 9900);
    check("ct_count",  32'(o_frame_count), 2);
    check("ct_err",    32'(o_err), 0);
    check("ct_busy",   32'(o_busy), 1);
    check("ct_tready", 32'(s_axis.tready), 1);

    // Early tlast on pix 6 of line 3, garbage dropped, then a clean frame
    snap();
    for (int i = 0; i < 37; i++) send(8'(i), (i == 0), (i % 10 == 9) || (i == 36));
    check("et_err",   32'(o_err), 3'b001);
    check("et_abort", 32'(o_frame_abort), 1);
    repeat (5) send(8'h77, 1'b0, 1'b0);
    send_frame(0, -1);
    idle(2);
    check("et_pixels", 32'(n_pix - s_pix), 137);
    check("et_aborts", 32'(n_abort - s_abort), 1);
    check("et_count",  32'(o_frame_count), 3);

    // Missing tlast at pix 9 of line 0; coincident clear and new error; clear
    pulse(2);
    check("mt_clr0", 32'(o_err), 0);
    for (int i = 0; i < 10; i++) send(8'(i), (i == 0), 1'b0);
    check("mt_err",   32'(o_err), 3'b010);
    check("mt_abort", 32'(o_frame_abort), 1);
    check("mt_busy",  32'(o_busy), 1);
    i_clear_err = 1'b1;
    send(8'h55, 1'b1, 1'b1);
    i_clear_err = 1'b0;
    check("mt_setdom", 32'(o_err), 3'b001);
    pulse(2);
    check("mt_clr1", 32'(o_err), 0);

    // Unexpected tuser at line 5 pix 2; frame completes 99 beats later
    snap();
    for (int i = 0; i < 52; i++) send(8'(i), (i == 0), (i % 10 == 9));
    send(8'hA5, 1'b1, 1'b0);
    check("ut_err",   32'(o_err), 3'b100);
    check("ut_abort", 32'(o_frame_abort), 1);
    check("ut_sof",   32'(o_start_of_frame), 1);
    for (int j = 1; j < 100; j++) send(8'(j), 1'b0, (j % 10 == 9));
    idle(2);
    check("ut_sof_idx",  32'(sof_idx), 32'(s_pix + 52));
    check("ut_done_idx", 32'(done_idx), 32'(s_pix + 152));
    check("ut_count",    32'(o_frame_count), 4);

    // Stop at line 4 in continuous mode lets the frame finish
    snap();
    send_frame(0, 40);
    idle(2);
    check("sp_done",  32'(n_done - s_done), 1);
    check("sp_count", 32'(o_frame_count), 5);
    check("sp_busy",  32'(o_busy), 0);

    // Stop on the final beat still counts as pending
    pulse(0);
    send_frame(0, 99);
    idle(1);
    check("sf_count", 32'(o_frame_count), 6);
    check("sf_busy",  32'(o_busy), 0);

    // Stop while waiting for sof
    pulse(0);
    check("sw_busy0", 32'(o_busy), 1);
    pulse(1);
    check("sw_busy1", 32'(o_busy), 0);

    // Asynchronous reset mid-frame
    pulse(0);
    for (int i = 0; i < 25; i++) send(8'(i + 1), (i == 0), (i % 10 == 9));
    check("ar_valid_pre", 32'(o_pixel_valid), 1);
    i_aresetn = 1'b0;
    #1;
    check("ar_valid", 32'(o_pixel_valid), 0);
    check("ar_pixel", 32'(o_pixel), 0);
    check("ar_count", 32'(o_frame_count), 0);
    check("ar_busy",  32'(o_busy), 0);
    check("ar_tready", 32'(s_axis.tready), 0);
    snap();
    idle(2);
    i_aresetn = 1'b1;
    idle(3);
    check("ar_no_abort", 32'(n_abort - s_abort), 0);
    check("ar_no_done",  32'(n_done - s_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
